// File: rtl/fifo2frm_nmap.sv
// ---------------------------------------------------------------------------
// fifo2frm_nmap
// Pops NUM_CH channel FIFOs in lockstep, unpacks PIX_W-bit pixels LSB-first
// from each FIFO word and emits one NUM_CH-wide pixel per accepted handshake,
// with sof/sol/eol/eof framing.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_fifo_empty        per-channel FIFO empty
//   i_fifo_popdata      channel c at [c*FDW +: FDW], valid one clock after pop
//   i_cfg_blk_en        block enable; rising edge starts a frame, low aborts
//   i_cfg_map_en        per-channel enable
//   i_cfg_img_width     pixels per line (>=1)
//   i_cfg_img_height    lines per frame (>=1)
//   i_frm_rdy           downstream ready
//   o_fifo_pop          single-cycle pop strobes
//   o_frm_val           pixel valid
//   o_frm_data          channel c at [c*PIX_W +: PIX_W], 0 for disabled maps
//   o_frm_sof/sol       first pixel of frame / line
//   o_frm_eol/eof       last pixel of line / frame
//   o_sts_frm_done      frame transferred; sticky until next start or disable
//
// state  | meaning
// S_IDLE | waiting for a start edge
// S_RUN  | popping words and streaming pixels
// S_DONE | eof pixel accepted, holding done status
// ---------------------------------------------------------------------------
module fifo2frm_nmap #(
    parameter int FIFO_DATA_WIDTH = 64,
    parameter int NUM_CH          = 3,
    parameter int PIX_W           = 8,
    parameter int DIM_W           = 11
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_CH-1:0]                 i_fifo_empty,
    input  logic [NUM_CH*FIFO_DATA_WIDTH-1:0] i_fifo_popdata,
    input  logic                              i_cfg_blk_en,
    input  logic [NUM_CH-1:0]                 i_cfg_map_en,
    input  logic [DIM_W-1:0]                  i_cfg_img_width,
    input  logic [DIM_W-1:0]                  i_cfg_img_height,
    input  logic                              i_frm_rdy,
    output logic [NUM_CH-1:0]                 o_fifo_pop,
    output logic                              o_frm_val,
    output logic [NUM_CH*PIX_W-1:0]           o_frm_data,
    output logic                              o_frm_sof,
    output logic                              o_frm_sol,
    output logic                              o_frm_eol,
    output logic                              o_frm_eof,
    output logic                              o_sts_frm_done
);

    localparam int FDW   = FIFO_DATA_WIDTH;
    localparam int PPW   = FDW / PIX_W;
    localparam int CNT_W = $clog2(PPW + 1);
    localparam int WC_W  = 2 * DIM_W;
    localparam logic [CNT_W-1:0] PPW_C = CNT_W'(PPW);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_blk_en_d;
    logic [NUM_CH-1:0]        r_en_m;
    logic [DIM_W-1:0]         r_width;
    logic [DIM_W-1:0]         r_height;
    logic [DIM_W-1:0]         r_pix_cnt;
    logic [DIM_W-1:0]         r_line_cnt;
    logic [WC_W-1:0]          r_words_tot;
    logic [WC_W-1:0]          r_words_pop;
    logic [NUM_CH-1:0]        r_pop;
    logic                     r_dv;
    logic [NUM_CH*FDW-1:0]    r_sr;
    logic [CNT_W-1:0]         r_sr_cnt;
    logic [NUM_CH*FDW-1:0]    r_buf;
    logic                     r_buf_v;
    logic                     r_done;

    logic                     w_start;
    logic                     w_val;
    logic                     w_acc;
    logic                     w_sol;
    logic                     w_eol;
    logic                     w_sof;
    logic                     w_eof;
    logic                     w_eof_acc;
    logic                     w_fifo_ok;
    logic                     w_pop;
    logic [WC_W-1:0]          w_words_tot;
    logic [NUM_CH*FDW-1:0]    w_sr_nxt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [NUM_CH*FDW-1:0]    w_buf_nxt;
    logic                     w_buf_v_nxt;

    assign w_start   = i_cfg_blk_en & ~r_blk_en_d & (|i_cfg_map_en);
    assign w_val     = (r_sr_cnt != '0);
    assign w_acc     = w_val & i_frm_rdy;
    assign w_sol     = (r_pix_cnt == '0);
    assign w_eol     = (r_pix_cnt == r_width - 1'b1);
    assign w_sof     = w_sol & (r_line_cnt == '0);
    assign w_eof     = w_eol & (r_line_cnt == r_height - 1'b1);
    assign w_eof_acc = w_acc & w_eof;

    // Words needed to cover W*H pixels; the tail of the last word is dropped at eof.
    assign w_words_tot = (WC_W'(i_cfg_img_width) * WC_W'(i_cfg_img_height) + WC_W'(PPW - 1))
                         / WC_W'(PPW);

    // Shift register drains one pixel per accept; refills from BUF or the
    // arriving word in the same clock it empties so output has no bubble.
    always_comb begin
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_sr_cnt;
        w_buf_nxt   = r_buf;
        w_buf_v_nxt = r_buf_v;
        if (w_acc) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_sr_nxt[c*FDW +: FDW] = r_sr[c*FDW +: FDW] >> PIX_W;
            end
            w_cnt_nxt = r_sr_cnt - 1'b1;
        end
        if (w_cnt_nxt == '0) begin
            if (r_buf_v) begin
                w_sr_nxt    = r_buf;
                w_cnt_nxt   = PPW_C;
                w_buf_v_nxt = r_dv;
                if (r_dv) begin
                    w_buf_nxt = i_fifo_popdata;
                end
            end else if (r_dv) begin
                w_sr_nxt  = i_fifo_popdata;
                w_cnt_nxt = PPW_C;
            end
        end else if (r_dv) begin
            w_buf_nxt   = i_fifo_popdata;
            w_buf_v_nxt = 1'b1;
        end
        if (w_eof_acc) begin
            w_cnt_nxt   = '0;
            w_buf_v_nxt = 1'b0;
        end
    end

    // Pop only when the word can land two clocks later: nothing in flight
    // and BUF empty after this edge, so SR or BUF is guaranteed free.
    assign w_fifo_ok = &(~i_fifo_empty | ~r_en_m);
    assign w_pop     = (r_state == S_RUN) & i_cfg_blk_en & w_fifo_ok & ~(|r_pop)
                       & ~w_buf_v_nxt & (r_words_pop < r_words_tot);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_blk_en_d  <= 1'b0;
            r_en_m      <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_words_tot <= '0;
            r_words_pop <= '0;
            r_pop       <= '0;
            r_dv        <= 1'b0;
            r_sr        <= '0;
            r_sr_cnt    <= '0;
            r_buf       <= '0;
            r_buf_v     <= 1'b0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_blk_en_d <= i_cfg_blk_en;
            if (!i_cfg_blk_en) begin
                r_state     <= S_IDLE;
                r_pop       <= '0;
                r_dv        <= 1'b0;
                r_sr_cnt    <= '0;
                r_buf_v     <= 1'b0;
                r_pix_cnt   <= '0;
                r_line_cnt  <= '0;
                r_words_pop <= '0;
                r_done      <= 1'b0;
            end else if (w_start) begin
                r_state     <= S_RUN;
                r_en_m      <= i_cfg_map_en;
                r_width     <= i_cfg_img_width;
                r_height    <= i_cfg_img_height;
                r_words_tot <= w_words_tot;
                r_words_pop <= '0;
                r_pop       <= '0;
                r_dv        <= 1'b0;
                r_sr_cnt    <= '0;
                r_buf_v     <= 1'b0;
                r_pix_cnt   <= '0;
                r_line_cnt  <= '0;
                r_done      <= 1'b0;
            end else begin
                r_pop    <= w_pop ? r_en_m : '0;
                r_dv     <= |r_pop;
                r_sr     <= w_sr_nxt;
                r_sr_cnt <= w_cnt_nxt;
                r_buf    <= w_buf_nxt;
                r_buf_v  <= w_buf_v_nxt;
                if (w_pop) begin
                    r_words_pop <= r_words_pop + 1'b1;
                end
                if (w_acc) begin
                    if (w_eol) begin
                        r_pix_cnt  <= '0;
                        r_line_cnt <= w_eof ? '0 : r_line_cnt + 1'b1;
                    end else begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end
                if (w_eof_acc) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_frm_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_val && r_en_m[c]) begin
                o_frm_data[c*PIX_W +: PIX_W] = r_sr[c*FDW +: PIX_W];
            end
        end
    end

    assign o_fifo_pop     = r_pop;
    assign o_frm_val      = w_val;
    assign o_frm_sof      = w_val & w_sof;
    assign o_frm_sol      = w_val & w_sol;
    assign o_frm_eol      = w_val & w_eol;
    assign o_frm_eof      = w_val & w_eof;
    assign o_sts_frm_done = r_done;

endmodule

// File: tb/tb_fifo2frm_nmap.sv
// Directed bench: default 3-channel instance (A) plus a 1-channel 32/16 instance (B).
// Each instance is fed by a FIFO model returning a deterministic word per pop.
module tb_fifo2frm_nmap;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: defaults (64-bit words, 3 ch, 8-bit pixels)
    logic [2:0]   a_empty, a_map, a_pop;
    logic [191:0] a_pd = '0;
    logic         a_en, a_rdy, a_val, a_sof, a_sol, a_eol, a_eof, a_done;
    logic [10:0]  a_w, a_h;
    logic [23:0]  a_data;
    int           a_widx[3] = '{default: 0};
    int           a_base[3] = '{default: 0};

    fifo2frm_nmap dut_a (
        .i_clk(clk), .i_rst(rst), .i_fifo_empty(a_empty), .i_fifo_popdata(a_pd),
        .i_cfg_blk_en(a_en), .i_cfg_map_en(a_map), .i_cfg_img_width(a_w),
        .i_cfg_img_height(a_h), .i_frm_rdy(a_rdy), .o_fifo_pop(a_pop),
        .o_frm_val(a_val), .o_frm_data(a_data), .o_frm_sof(a_sof), .o_frm_sol(a_sol),
        .o_frm_eol(a_eol), .o_frm_eof(a_eof), .o_sts_frm_done(a_done));

    // ---------------- instance B: 1 ch, 32-bit words, 16-bit pixels
    logic [0:0]   b_empty, b_map, b_pop;
    logic [31:0]  b_pd = '0;
    logic         b_en, b_rdy, b_val, b_sof, b_sol, b_eol, b_eof, b_done;
    logic [10:0]  b_w, b_h;
    logic [15:0]  b_data;
    int           b_widx = 0;
    int           b_base = 0;

    fifo2frm_nmap #(.FIFO_DATA_WIDTH(32), .NUM_CH(1), .PIX_W(16), .DIM_W(11)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_fifo_empty(b_empty), .i_fifo_popdata(b_pd),
        .i_cfg_blk_en(b_en), .i_cfg_map_en(b_map), .i_cfg_img_width(b_w),
        .i_cfg_img_height(b_h), .i_frm_rdy(b_rdy), .o_fifo_pop(b_pop),
        .o_frm_val(b_val), .o_frm_data(b_data), .o_frm_sof(b_sof), .o_frm_sol(b_sol),
        .o_frm_eol(b_eol), .o_frm_eof(b_eof), .o_sts_frm_done(b_done));

    // Pixel p of word n on channel c
    function automatic logic [7:0] pa(int c, int n, int p);
        return 8'((n * 8 + p) * 5 + c * 77 + 3);
    endfunction

    function automatic logic [63:0] mk_a(int c, int n);
        logic [63:0] w;
        for (int p = 0; p < 8; p++) w[p*8 +: 8] = pa(c, n, p);
        return w;
    endfunction

    function automatic logic [15:0] pb(int n, int p);
        return 16'(32'hA000 + n * 16 + p);
    endfunction

    // FIFO models: word appears the clock after the pop strobe
    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (a_pop[c]) begin
                a_pd[c*64 +: 64] <= mk_a(c, a_widx[c]);
                a_widx[c]        <= a_widx[c] + 1;
            end
        end
        if (b_pop[0]) begin
            b_pd   <= {pb(b_widx, 1), pb(b_widx, 0)};
            b_widx <= b_widx + 1;
        end
    end

    // Expected frame pixel k of instance A, relative to the words at frame start
    function automatic logic [23:0] exp_a(int k);
        logic [23:0] e = '0;
        for (int c = 0; c < 3; c++)
            if (a_map[c]) e[c*8 +: 8] = pa(c, a_base[c] + k / 8, k % 8);
        return e;
    endfunction

    function automatic logic [3:0] exp_flags(int k, int w, int h);
        return {k == 0, (k % w) == 0, (k % w) == w - 1, k == w * h - 1};
    endfunction

    task automatic start_a(int w, int h, logic [2:0] map);
        a_w = 11'(w); a_h = 11'(h); a_map = map; a_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) a_base[c] = a_widx[c];
        a_en = 1'b1;
    endtask

    task automatic stop_a();
        a_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_val, a_pop, a_done, a_sof, a_sol, a_eol, a_eof} !== '0) begin
            errors++; $display("FAIL reset_a_ctrl got %b exp 0", {a_val, a_pop, a_done, a_sof, a_sol, a_eol, a_eof});
        end
        checks++;
        if (a_data !== 24'h0) begin errors++; $display("FAIL reset_a_data got %h exp 0", a_data); end
        checks++;
        if ({b_val, b_pop, b_done, b_data} !== '0) begin
            errors++; $display("FAIL reset_b got %h exp 0", {b_val, b_pop, b_done, b_data});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_val, a_pop, a_done, b_val, b_pop, b_done} !== '0) begin
            errors++; $display("FAIL post_reset_idle got %b exp 0", {a_val, a_pop, a_done, b_val, b_pop, b_done});
        end
    endtask

    task automatic test_ignore_start();
        int act = 0;
        start_a(16, 2, 3'b000);
        repeat (12) begin
            @(negedge clk);
            if (a_val || a_pop != 3'b000) act++;
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL ignore_start active_cycles got %0d exp 0", act); end
        stop_a();
    endtask

    task automatic test_basic();
        int cyc = 0, k = 0, pops = 0, first = -1, gaps = 0;
        start_a(16, 2, 3'b111);
        a_rdy = 1'b1;
        while (k < 32 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (a_pop != 3'b000) begin
                pops++;
                checks++;
                if (a_pop !== 3'b111) begin errors++; $display("FAIL basic_pop_mask got %b exp 111", a_pop); end
            end
            if (a_val && a_rdy) begin
                if (first < 0) first = cyc;
                checks++;
                if (a_data !== exp_a(k)) begin errors++; $display("FAIL basic_data k=%0d got %h exp %h", k, a_data, exp_a(k)); end
                checks++;
                if ({a_sof, a_sol, a_eol, a_eof} !== exp_flags(k, 16, 2)) begin
                    errors++; $display("FAIL basic_flags k=%0d got %b exp %b", k, {a_sof, a_sol, a_eol, a_eof}, exp_flags(k, 16, 2));
                end
                k++;
            end else if (first >= 0) gaps++;
        end
        checks++;
        if (k != 32) begin errors++; $display("FAIL basic_pixel_count got %0d exp 32", k); end
        checks++;
        if (first != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", first); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL basic_back_to_back gaps got %0d exp 0", gaps); end
        @(negedge clk);
        checks++;
        if ({a_val, a_done} !== 2'b01) begin errors++; $display("FAIL basic_done got val,done=%b exp 01", {a_val, a_done}); end
        repeat (10) begin
            @(negedge clk);
            if (a_pop != 3'b000) pops++;
        end
        checks++;
        if (pops != 4) begin errors++; $display("FAIL basic_pops got %0d exp 4", pops); end
        checks++;
        if (a_done !== 1'b1) begin errors++; $display("FAIL basic_done_sticky got %b exp 1", a_done); end
        a_en = 1'b0;
        @(negedge clk);
        checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL basic_done_clear got %b exp 0", a_done); end
        stop_a();
    endtask

    task automatic test_partial();
        int cyc = 0, k = 0, pops = 0, late = 0;
        start_a(5, 3, 3'b111);
        a_rdy = 1'b1;
        while (k < 15 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (a_pop != 3'b000) pops++;
            if (a_val && a_rdy) begin
                checks++;
                if (a_data !== exp_a(k)) begin errors++; $display("FAIL partial_data k=%0d got %h exp %h", k, a_data, exp_a(k)); end
                checks++;
                if ({a_sof, a_sol, a_eol, a_eof} !== exp_flags(k, 5, 3)) begin
                    errors++; $display("FAIL partial_flags k=%0d got %b exp %b", k, {a_sof, a_sol, a_eol, a_eof}, exp_flags(k, 5, 3));
                end
                k++;
            end
        end
        checks++;
        if (k != 15) begin errors++; $display("FAIL partial_pixel_count got %0d exp 15", k); end
        repeat (20) begin
            @(negedge clk);
            if (a_pop != 3'b000) pops++;
            if (a_val) late++;
        end
        checks++;
        if (late != 0) begin errors++; $display("FAIL partial_discard val_cycles got %0d exp 0", late); end
        checks++;
        if (pops != 2) begin errors++; $display("FAIL partial_pops got %0d exp 2", pops); end
        stop_a();
    endtask

    task automatic test_map_mask();
        int cyc = 0, k = 0, pop1 = 0;
        start_a(16, 1, 3'b101);
        a_rdy = 1'b1;
        while (k < 16 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (a_pop[1]) pop1++;
            if (a_val && a_rdy) begin
                checks++;
                if (a_data[15:8] !== 8'h00) begin errors++; $display("FAIL mask_ch1_zero k=%0d got %h exp 00", k, a_data[15:8]); end
                checks++;
                if (a_data !== exp_a(k)) begin errors++; $display("FAIL mask_data k=%0d got %h exp %h", k, a_data, exp_a(k)); end
                k++;
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (k != 16) begin errors++; $display("FAIL mask_pixel_count got %0d exp 16", k); end
        checks++;
        if (pop1 != 0 || a_widx[1] != a_base[1]) begin errors++; $display("FAIL mask_ch1_pop got %0d exp 0", pop1); end
        checks++;
        if (a_widx[0] - a_base[0] != 2 || a_widx[2] - a_base[2] != 2) begin
            errors++; $display("FAIL mask_words got %0d/%0d exp 2/2", a_widx[0] - a_base[0], a_widx[2] - a_base[2]);
        end
        stop_a();
    endtask

    task automatic test_rdy_random();
        int cyc = 0, k = 0;
        logic held_v = 1'b0;
        logic [28:0] held = '0, now;
        start_a(12, 3, 3'b111);
        a_rdy = 1'b0;
        while (k < 36 && cyc < 2000) begin
            @(negedge clk); cyc++;
            now = {a_val, a_data, a_sof, a_sol, a_eol, a_eof};
            if (held_v) begin
                checks++;
                if (now !== held) begin errors++; $display("FAIL stall_stable k=%0d got %h exp %h", k, now, held); end
            end
            a_rdy = 1'($urandom_range(0, 1));
            a_empty = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (a_val && a_rdy) begin
                checks++;
                if (a_data !== exp_a(k)) begin errors++; $display("FAIL random_data k=%0d got %h exp %h", k, a_data, exp_a(k)); end
                checks++;
                if ({a_sof, a_sol, a_eol, a_eof} !== exp_flags(k, 12, 3)) begin
                    errors++; $display("FAIL random_flags k=%0d got %b exp %b", k, {a_sof, a_sol, a_eol, a_eof}, exp_flags(k, 12, 3));
                end
                k++;
                held_v = 1'b0;
            end else begin
                held_v = a_val;
                held   = now;
            end
        end
        checks++;
        if (k != 36) begin errors++; $display("FAIL random_pixel_count got %0d exp 36", k); end
        a_rdy = 1'b1; a_empty = 3'b000;
        stop_a();
    endtask

    task automatic test_abort();
        int cyc = 0, k = 0, act = 0;
        start_a(8, 4, 3'b111);
        a_rdy = 1'b1;
        while (k < 20 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (a_val && a_rdy) begin
                checks++;
                if (a_data !== exp_a(k)) begin errors++; $display("FAIL abort_pre_data k=%0d got %h exp %h", k, a_data, exp_a(k)); end
                k++;
            end
        end
        a_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_val, a_pop} !== 4'b0000) begin errors++; $display("FAIL abort_stop got val,pop=%b exp 0000", {a_val, a_pop}); end
        repeat (8) begin
            @(negedge clk);
            if (a_val || a_pop != 3'b000 || a_done) act++;
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL abort_quiet got %0d exp 0", act); end
        start_a(8, 4, 3'b111);
        cyc = 0; k = 0;
        while (k < 32 && cyc < 300) begin
            @(negedge clk); cyc++;
            if (a_val && a_rdy) begin
                checks++;
                if (a_data !== exp_a(k)) begin errors++; $display("FAIL abort_restart_data k=%0d got %h exp %h", k, a_data, exp_a(k)); end
                checks++;
                if ({a_sof, a_sol, a_eol, a_eof} !== exp_flags(k, 8, 4)) begin
                    errors++; $display("FAIL abort_restart_flags k=%0d got %b exp %b", k, {a_sof, a_sol, a_eol, a_eof}, exp_flags(k, 8, 4));
                end
                k++;
            end
        end
        @(negedge clk);
        checks++;
        if (k != 32 || a_done !== 1'b1) begin errors++; $display("FAIL abort_restart_end got k=%0d done=%b exp 32/1", k, a_done); end
        stop_a();
    endtask

    task automatic test_single_ch();
        int cyc = 0, k = 0, pops = 0;
        logic [15:0] e;
        b_w = 11'd1; b_h = 11'd4; b_map = 1'b1; b_en = 1'b0;
        @(negedge clk);
        b_base = b_widx;
        b_en = 1'b1;
        while (k < 4 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (b_pop[0]) pops++;
            if (b_val && b_rdy) begin
                e = pb(b_base + k / 2, k % 2);
                checks++;
                if (b_data !== e) begin errors++; $display("FAIL single_data k=%0d got %h exp %h", k, b_data, e); end
                checks++;
                if ({b_sof, b_sol, b_eol, b_eof} !== exp_flags(k, 1, 4)) begin
                    errors++; $display("FAIL single_flags k=%0d got %b exp %b", k, {b_sof, b_sol, b_eol, b_eof}, exp_flags(k, 1, 4));
                end
                k++;
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (b_pop[0]) pops++;
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL single_pixel_count got %0d exp 4", k); end
        checks++;
        if (pops != 2) begin errors++; $display("FAIL single_pops got %0d exp 2", pops); end
        checks++;
        if ({b_val, b_done} !== 2'b01) begin errors++; $display("FAIL single_done got val,done=%b exp 01", {b_val, b_done}); end
        b_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_empty = 3'b000; a_map = 3'b111; a_en = 1'b0; a_rdy = 1'b1; a_w = 11'd16; a_h = 11'd2;
        b_empty = 1'b0; b_map = 1'b1; b_en = 1'b0; b_rdy = 1'b1; b_w = 11'd1; b_h = 11'd4;
        @(negedge clk);
        test_reset();
        test_ignore_start();
        test_basic();
        test_partial();
        test_map_mask();
        test_rdy_random();
        test_abort();
        test_single_ch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
